instr_stream_loader: RTL and testbench

- Sequential instruction encoder and writer; the producing end of the opcode/control path.
- Accepts field-level instruction requests over a valid/ready handshake.
- Encodes each request into a 32-bit MIPS word (R-type, lw, sw, beq, j) and writes it into instruction memory at consecutive word addresses.
- Used by the test infrastructure and boot path to populate imem before the datapath and control decoder run.

---
 rtl/mips_isa_pkg.sv | 32 +++
 rtl/instr_stream_loader_if.sv | 26 ++
 rtl/instr_field_encoder.sv | 32 +++
 rtl/instr_stream_loader.sv | 137 +++++++++++++
 tb/tb_instr_stream_loader.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the instruction loader and the control decoder:
// major opcodes, R-type funct codes, the loader op_kind enum and its FSM states.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Request kinds on the loader input; encodings 5-7 are illegal.
  typedef enum logic [2:0] {
    K_RTYPE = 3'd0,
    K_LW    = 3'd1,
    K_SW    = 3'd2,
    K_BEQ   = 3'd3,
    K_J     = 3'd4
  } op_kind_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } ldr_state_e;

endpackage

// File: rtl/instr_stream_loader_if.sv
// Request channel (valid/ready + instruction fields) and imem write bus of the
// instruction stream loader. master = request producer / memory side,
// slave = the loader.
interface instr_stream_loader_if #(parameter int ADDR_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op_kind;
  logic [4:0]        rs, rt, rd, shamt;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, op_kind, rs, rt, rd, shamt, funct, imm, target, last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, op_kind, rs, rt, rd, shamt, funct, imm, target, last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_field_encoder.sv
// Combinational MIPS encoder: op_kind plus raw fields -> 32-bit word.
// Fields not used by the selected format are ignored; kinds 5-7 flag illegal.
module instr_field_encoder
  import mips_isa_pkg::*;
(
  input  logic [2:0]  op_kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Format select by request kind.
  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    case (op_kind)
      K_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      K_LW:    word = {OP_LW, rs, rt, imm};
      K_SW:    word = {OP_SW, rs, rt, imm};
      K_BEQ:   word = {OP_BEQ, rs, rt, imm};
      K_J:     word = {OP_J, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_stream_loader.sv
// Instruction stream loader: accepts field-level requests, encodes them and
// writes consecutive imem words starting at BASE_ADDR, one cycle after accept.
// Optional macro LOADER_CHECKSUM_EN adds an XOR checksum of written words.
module instr_stream_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  instr_stream_loader_if.slave bus,
  output logic                busy,
  output logic                done,
  output logic                err_illegal,
  output logic                err_full,
  output logic [ADDR_W:0]     count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]         checksum
`endif
);

  localparam logic [ADDR_W:0]   CAP  = (ADDR_W+1)'((1 << ADDR_W) - BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  ldr_state_e        state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic              we_r;
  logic              fin;        // last has been accepted this session
  logic              in_ready;
  logic [31:0]       enc_word;
  logic              enc_illegal;

  // Slots already claimed = written words + the one write in flight.
  logic [ADDR_W:0] issued, count_inc;
  logic            xfer, full_hit, enter;

  assign issued    = count + (ADDR_W+1)'(we_r);
  assign count_inc = count + (ADDR_W+1)'(1);
  assign xfer      = bus.in_valid & in_ready;
  assign full_hit  = we_r && (count_inc == CAP);
  assign enter     = (state != S_LOAD) && (state_n == S_LOAD);

  instr_field_encoder u_enc (
    .op_kind (bus.op_kind),
    .rs      (bus.rs),
    .rt      (bus.rt),
    .rd      (bus.rd),
    .shamt   (bus.shamt),
    .funct   (bus.funct),
    .imm     (bus.imm),
    .target  (bus.target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state and handshake ready; session ends after the last write or
  // when the write filling the final slot lands.
  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    case (state)
      S_IDLE: if (start) state_n = S_LOAD;
      S_LOAD: begin
        in_ready = !fin && (issued < CAP);
        if (fin || full_hit) state_n = S_DONE;
      end
      S_DONE: if (start) state_n = S_LOAD;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: output register, pointer, count, sticky flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      ptr         <= BASE;
      count       <= '0;
      fin         <= 1'b0;
      err_illegal <= 1'b0;
      err_full    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      we_r <= xfer & ~enc_illegal;
      if (enter) begin
        ptr         <= BASE;
        count       <= '0;
        fin         <= 1'b0;
        err_illegal <= 1'b0;
        err_full    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        checksum    <= '0;
`endif
      end else if (state == S_LOAD) begin
        if (we_r) begin
          count <= count_inc;
`ifdef LOADER_CHECKSUM_EN
          checksum <= checksum ^ wdata_r;
`endif
        end
        if (xfer) begin
          if (enc_illegal) begin
            err_illegal <= 1'b1;
          end else begin
            addr_r  <= ptr;
            wdata_r <= enc_word;
            ptr     <= ptr + ADDR_W'(1);
          end
          if (bus.last) fin <= 1'b1;
        end
        if (full_hit && !fin) err_full <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = we_r;
  assign bus.imem_addr  = addr_r;
  assign bus.imem_wdata = wdata_r;
  assign busy           = (state == S_LOAD);
  assign done           = (state == S_DONE);

endmodule

// File: tb/tb_instr_stream_loader.sv
// Directed bench for instr_stream_loader: default-size instance u0 plus a
// 4-word instance u1 for the capacity case. Checksum checked when
// LOADER_CHECKSUM_EN is defined.
module tb_instr_stream_loader;
  import mips_isa_pkg::*;

  logic clk = 1'b0;
  logic rst_n, start0, start1, valid0, valid1;
  logic [2:0]  op_kind;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;
  logic        last;
  logic        busy0, done0, eill0, efull0, busy1, done1, eill1, efull1;
  logic [8:0]  count0;
  logic [2:0]  count1;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum0, csum1;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_stream_loader_if #(.ADDR_W(8)) bus0 ();
  instr_stream_loader_if #(.ADDR_W(2)) bus1 ();

  assign bus0.in_valid = valid0;  assign bus1.in_valid = valid1;
  assign bus0.op_kind = op_kind;  assign bus1.op_kind = op_kind;
  assign bus0.rs = rs;            assign bus1.rs = rs;
  assign bus0.rt = rt;            assign bus1.rt = rt;
  assign bus0.rd = rd;            assign bus1.rd = rd;
  assign bus0.shamt = shamt;      assign bus1.shamt = shamt;
  assign bus0.funct = funct;      assign bus1.funct = funct;
  assign bus0.imm = imm;          assign bus1.imm = imm;
  assign bus0.target = target;    assign bus1.target = target;
  assign bus0.last = last;        assign bus1.last = last;

  instr_stream_loader #(.ADDR_W(8), .BASE_ADDR(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bus(bus0),
    .busy(busy0), .done(done0), .err_illegal(eill0), .err_full(efull0),
    .count(count0)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(csum0)
`endif
  );

  instr_stream_loader #(.ADDR_W(2), .BASE_ADDR(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(bus1),
    .busy(busy1), .done(done1), .err_illegal(eill1), .err_full(efull1),
    .count(count1)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(csum1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] k, input logic [4:0] rs_, input logic [4:0] rt_,
                     input logic [4:0] rd_, input logic [5:0] fn, input logic [15:0] im,
                     input logic [25:0] tg, input logic l);
    op_kind = k; rs = rs_; rt = rt_; rd = rd_; shamt = 5'd0;
    funct = fn; imm = im; target = tg; last = l;
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
    req(3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
    tick(); tick();

    // Reset state
    chk("rst_we", bus0.imem_we, 0);
    chk("rst_addr", bus0.imem_addr, 0);
    chk("rst_wdata", bus0.imem_wdata, 0);
    chk("rst_ready", bus0.in_ready, 0);
    chk("rst_flags", {busy0, done0, eill0, efull0}, 0);
    chk("rst_count", count0, 0);
    chk("rst_u1", {bus1.imem_we, busy1, done1, efull1, count1}, 0);
`ifdef LOADER_CHECKSUM_EN
    chk("rst_csum", csum0, 0);
`endif
    rst_n = 1'b1;

    // Single RTYPE with last
    start0 = 1'b1; tick(); start0 = 1'b0;
    chk("t1_busy", busy0, 1);
    chk("t1_ready", bus0.in_ready, 1);
    valid0 = 1'b1; req(K_RTYPE, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, 1'b1);
    tick(); valid0 = 1'b0;
    chk("t1_we", bus0.imem_we, 1);
    chk("t1_addr", bus0.imem_addr, 0);
    chk("t1_wdata", bus0.imem_wdata, 32'h00221820);
    chk("t1_ready_after_last", bus0.in_ready, 0);
    tick();
    chk("t1_done", done0, 1);
    chk("t1_count", count0, 1);
    chk("t1_we_off", bus0.imem_we, 0);
`ifdef LOADER_CHECKSUM_EN
    chk("t1_csum", csum0, 32'h00221820);
`endif

    // Back-to-back LW / SW / BEQ / J
    start0 = 1'b1; tick(); start0 = 1'b0;
    chk("t2_count_clr", count0, 0);
    valid0 = 1'b1; req(K_LW, 5'd29, 5'd8, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0);
    tick();
    chk("t2_w0", {bus0.imem_we, bus0.imem_addr, bus0.imem_wdata}, {1'b1, 8'd0, 32'h8FA80004});
    req(K_SW, 5'd29, 5'd8, 5'd0, 6'd0, 16'h0008, 26'd0, 1'b0);
    tick();
    chk("t2_w1", {bus0.imem_we, bus0.imem_addr, bus0.imem_wdata}, {1'b1, 8'd1, 32'hAFA80008});
    req(K_BEQ, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
    tick();
    chk("t2_w2", {bus0.imem_we, bus0.imem_addr, bus0.imem_wdata}, {1'b1, 8'd2, 32'h1022FFFF});
    req(K_J, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b1);
    tick(); valid0 = 1'b0;
    chk("t2_w3", {bus0.imem_we, bus0.imem_addr, bus0.imem_wdata}, {1'b1, 8'd3, 32'h08000010});
    tick();
    chk("t2_done", done0, 1);
    chk("t2_count", count0, 4);

    // Illegal op_kind between two RTYPEs; start during LOAD is ignored
    start0 = 1'b1; tick(); start0 = 1'b0;
    chk("t3_illegal_clr", eill0, 0);
    valid0 = 1'b1; req(K_RTYPE, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, 1'b0);
    tick();
    chk("t3_w0", {bus0.imem_we, bus0.imem_addr, bus0.imem_wdata}, {1'b1, 8'd0, 32'h00221820});
    req(3'd6, 5'd7, 5'd7, 5'd7, 6'h3F, 16'hBEEF, 26'h3FFFFFF, 1'b0);
    start0 = 1'b1;
    tick(); start0 = 1'b0;
    chk("t3_no_write", bus0.imem_we, 0);
    req(K_RTYPE, 5'd4, 5'd5, 5'd6, 6'h22, 16'd0, 26'd0, 1'b1);
    tick(); valid0 = 1'b0;
    chk("t3_w1", {bus0.imem_we, bus0.imem_addr, bus0.imem_wdata}, {1'b1, 8'd1, 32'h00853022});
    tick();
    chk("t3_end", {done0, eill0, efull0, count0}, {1'b1, 1'b1, 1'b0, 9'd2});

    // Capacity on 4-word instance: five requests, no last
    start1 = 1'b1; tick(); start1 = 1'b0;
    valid1 = 1'b1; req(K_RTYPE, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t4_w%0d", i), {bus1.imem_we, bus1.imem_addr}, {1'b1, 2'(i)});
    end
    chk("t4_ready_fifth", bus1.in_ready, 0);
    tick();
    chk("t4_end", {done1, efull1, eill1, count1, bus1.imem_we, bus1.in_ready},
        {1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0});
    valid1 = 1'b0;

    // Reset mid-session after two writes, then restart at addr 0
    start0 = 1'b1; tick(); start0 = 1'b0;
    valid0 = 1'b1; req(K_RTYPE, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, 1'b0);
    tick();
    tick();
    chk("t5_w1", {bus0.imem_we, bus0.imem_addr}, {1'b1, 8'd1});
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; valid0 = 1'b0;
    chk("t5_rst_out", {bus0.imem_we, bus0.imem_addr, bus0.imem_wdata, bus0.in_ready,
                       busy0, done0, eill0, efull0, count0}, 0);
    start0 = 1'b1; tick(); start0 = 1'b0;
    valid0 = 1'b1; req(K_LW, 5'd29, 5'd8, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b1);
    tick(); valid0 = 1'b0;
    chk("t5_restart", {bus0.imem_we, bus0.imem_addr, bus0.imem_wdata}, {1'b1, 8'd0, 32'h8FA80004});
    tick();
    chk("t5_done", {done0, count0}, {1'b1, 9'd1});

`ifdef LOADER_CHECKSUM_EN
    // Checksum over two words
    start0 = 1'b1; tick(); start0 = 1'b0;
    chk("t6_csum_clr", csum0, 0);
    valid0 = 1'b1; req(K_RTYPE, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, 1'b0);
    tick();
    req(K_J, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b1);
    tick(); valid0 = 1'b0;
    tick();
    chk("t6_csum", csum0, 32'h08221830);
    tick();
    chk("t6_csum_hold", csum0, 32'h08221830);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
